// File: rtl/fsm_dp_if.sv
// Control-word and result bundle between the calculator control unit and the fsm_dp datapath.
interface fsm_dp_if #(
  parameter int unsigned W = 4
);
  logic [W-1:0] In1;
  logic [W-1:0] In2;
  logic [1:0]   Sel1;
  logic [1:0]   WA;
  logic         WE;
  logic [1:0]   RAA;
  logic         REA;
  logic [1:0]   RAB;
  logic         REB;
  logic [1:0]   C;
  logic         Sel2;
  logic         Done;
  logic [W-1:0] Out;
  logic         Valid;
  logic         Cout;
  logic         Zero;

  modport master (
    output In1, In2, Sel1, WA, WE, RAA, REA, RAB, REB, C, Sel2, Done,
    input  Out, Valid, Cout, Zero
  );

  modport slave (
    input  In1, In2, Sel1, WA, WE, RAA, REA, RAB, REB, C, Sel2, Done,
    output Out, Valid, Cout, Zero
  );
endinterface

// File: rtl/fsm_dp.sv
// Calculator datapath: input mux, 4-entry register file, ALU, registered result and status.
// Optional carry/zero flags are built only when FSM_DP_FLAGS_EN is defined.
module fsm_dp #(
  parameter int unsigned W = 4
) (
  input logic     CLK,
  input logic     RST_n,
  fsm_dp_if.slave bus
);
  localparam int unsigned NREGS = 4;

  logic [W-1:0] rf [NREGS];
  logic [W-1:0] rd_a;
  logic [W-1:0] rd_b;
  logic [W-1:0] alu_res;
  logic [W-1:0] wr_data;

  // Read ports see the array contents before this edge's write
  always_comb begin
    rd_a = bus.REA ? rf[bus.RAA] : '0;
    rd_b = bus.REB ? rf[bus.RAB] : '0;
  end

  always_comb begin
    alu_res = '0;
    unique case (bus.C)
      2'b00: alu_res = rd_a + rd_b;
      2'b01: alu_res = rd_a - rd_b;
      2'b10: alu_res = rd_a & rd_b;
      2'b11: alu_res = rd_a ^ rd_b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    wr_data = '0;
    unique case (bus.Sel1)
      2'b11: wr_data = bus.In1;
      2'b10: wr_data = bus.In2;
      2'b00: wr_data = alu_res;
      2'b01: wr_data = '0;
      default: wr_data = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      for (int i = 0; i < NREGS; i++) begin
        rf[i] <= '0;
      end
    end else if (bus.WE) begin
      rf[bus.WA] <= wr_data;
    end
  end

  // Out captures the pre-write ALU result even when the same word writes back
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      bus.Out   <= '0;
      bus.Valid <= 1'b0;
    end else begin
      if (bus.Sel2) begin
        bus.Out <= alu_res;
      end
      bus.Valid <= bus.Sel2 & bus.Done;
    end
  end

`ifdef FSM_DP_FLAGS_EN
  logic alu_carry;
  logic flag_load;

  // a+b overflows exactly when a > ~b; subtract borrows when a < b
  always_comb begin
    alu_carry = 1'b0;
    unique case (bus.C)
      2'b00: alu_carry = (rd_a > ~rd_b);
      2'b01: alu_carry = (rd_a < rd_b);
      default: alu_carry = 1'b0;
    endcase
  end

  assign flag_load = bus.WE && (bus.Sel1 == 2'b00);

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      bus.Cout <= 1'b0;
      bus.Zero <= 1'b0;
    end else if (flag_load) begin
      bus.Cout <= alu_carry;
      bus.Zero <= (alu_res == '0);
    end
  end
`else
  assign bus.Cout = 1'b0;
  assign bus.Zero = 1'b0;
`endif
endmodule

// File: tb/tb_fsm_dp.sv
// Directed table-driven bench for fsm_dp: one control word per cycle, outputs checked 1 time unit after each edge.
module tb_fsm_dp;
  localparam int unsigned W = 4;
`ifdef FSM_DP_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  typedef struct {
    logic         rst_n;
    logic [1:0]   sel1;
    logic [1:0]   wa;
    logic         we;
    logic [1:0]   raa;
    logic         rea;
    logic [1:0]   rab;
    logic         reb;
    logic [1:0]   c;
    logic         sel2;
    logic         done;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [W-1:0] eo;
    logic         ev;
    logic         ec;
    logic         ez;
  } vec_t;

  logic CLK;
  logic RST_n;
  int   checks;
  int   errors;
  int   idx;
  vec_t tbl[$];

  fsm_dp_if #(.W(W)) bus ();

  fsm_dp #(.W(W)) dut (
    .CLK  (CLK),
    .RST_n(RST_n),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic vec_t mk(logic rst_n, logic [1:0] sel1, logic [1:0] wa, logic we,
                              logic [1:0] raa, logic rea, logic [1:0] rab, logic reb,
                              logic [1:0] c, logic sel2, logic done,
                              logic [W-1:0] in1, logic [W-1:0] in2,
                              logic [W-1:0] eo, logic ev, logic ec, logic ez);
    vec_t v;
    v.rst_n = rst_n; v.sel1 = sel1; v.wa = wa; v.we = we;
    v.raa = raa; v.rea = rea; v.rab = rab; v.reb = reb;
    v.c = c; v.sel2 = sel2; v.done = done; v.in1 = in1; v.in2 = in2;
    v.eo = eo; v.ev = ev; v.ec = ec; v.ez = ez;
    return v;
  endfunction

  function automatic vec_t ld_a(logic [W-1:0] d, logic [W-1:0] eo, logic ec, logic ez);
    return mk(1, 2'b11, 2'd1, 1, 2'd0, 0, 2'd0, 0, 2'b00, 0, 0, d, 4'd0, eo, 0, ec, ez);
  endfunction

  function automatic vec_t ld_b(logic [W-1:0] d, logic [W-1:0] eo, logic ec, logic ez);
    return mk(1, 2'b10, 2'd2, 1, 2'd0, 0, 2'd0, 0, 2'b00, 0, 0, 4'd0, d, eo, 0, ec, ez);
  endfunction

  function automatic vec_t op(logic [1:0] c, logic [W-1:0] eo, logic ec, logic ez);
    return mk(1, 2'b00, 2'd3, 1, 2'd1, 1, 2'd2, 1, c, 0, 0, 4'd0, 4'd0, eo, 0, ec, ez);
  endfunction

  function automatic vec_t disp(logic [W-1:0] eo, logic ec, logic ez);
    return mk(1, 2'b00, 2'd0, 0, 2'd3, 1, 2'd3, 1, 2'b10, 1, 1, 4'd0, 4'd0, eo, 1, ec, ez);
  endfunction

  function automatic vec_t idle(logic [W-1:0] eo, logic ec, logic ez);
    return mk(1, 2'b00, 2'd0, 0, 2'd0, 0, 2'd0, 0, 2'b00, 0, 0, 4'd0, 4'd0, eo, 0, ec, ez);
  endfunction

  task automatic check1(string name, int n, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, n, act, exp);
    end
  endtask

  task automatic run_vec(vec_t v);
    RST_n    = v.rst_n;
    bus.Sel1 = v.sel1; bus.WA  = v.wa;  bus.WE  = v.we;
    bus.RAA  = v.raa;  bus.REA = v.rea; bus.RAB = v.rab; bus.REB = v.reb;
    bus.C    = v.c;    bus.Sel2 = v.sel2; bus.Done = v.done;
    bus.In1  = v.in1;  bus.In2 = v.in2;
    @(posedge CLK);
    #1;
    check1("out",   idx, bus.Out, v.eo);
    check1("valid", idx, 4'(bus.Valid), 4'(v.ev));
    check1("cout",  idx, 4'(bus.Cout),  4'(v.ec & FLAGS));
    check1("zero",  idx, 4'(bus.Zero),  4'(v.ez & FLAGS));
    idx++;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idx    = 0;

    // Reset with a write, load and Done on the same edge: reset must win
    tbl.push_back(mk(0, 2'b11, 2'd3, 1, 2'd0, 0, 2'd0, 0, 2'b00, 1, 1, 4'd15, 4'd0, 4'd0, 0, 0, 0));
    // 9 + 5
    tbl.push_back(ld_a(4'd9, 4'd0, 0, 0));
    tbl.push_back(ld_b(4'd5, 4'd0, 0, 0));
    tbl.push_back(op(2'b00, 4'd0, 0, 0));
    tbl.push_back(disp(4'd14, 0, 0));
    tbl.push_back(idle(4'd14, 0, 0));
    // 5 - 9 borrows
    tbl.push_back(ld_a(4'd5, 4'd14, 0, 0));
    tbl.push_back(ld_b(4'd9, 4'd14, 0, 0));
    tbl.push_back(op(2'b01, 4'd14, 1, 0));
    tbl.push_back(disp(4'd12, 1, 0));
    tbl.push_back(idle(4'd12, 1, 0));
    // 9 - 9 is zero
    tbl.push_back(ld_a(4'd9, 4'd12, 1, 0));
    tbl.push_back(ld_b(4'd9, 4'd12, 1, 0));
    tbl.push_back(op(2'b01, 4'd12, 0, 1));
    tbl.push_back(disp(4'd0, 0, 1));
    // 12 and/xor/add 10
    tbl.push_back(ld_a(4'd12, 4'd0, 0, 1));
    tbl.push_back(ld_b(4'd10, 4'd0, 0, 1));
    tbl.push_back(op(2'b10, 4'd0, 0, 0));
    tbl.push_back(disp(4'd8, 0, 0));
    tbl.push_back(op(2'b11, 4'd8, 0, 0));
    tbl.push_back(disp(4'd6, 0, 0));
    tbl.push_back(op(2'b00, 4'd6, 1, 0));
    tbl.push_back(disp(4'd6, 1, 0));
    tbl.push_back(disp(4'd6, 1, 0));
    // Done without Sel2: no pulse, Out holds
    tbl.push_back(mk(1, 2'b00, 2'd0, 0, 2'd3, 1, 2'd3, 1, 2'b10, 0, 1, 4'd0, 4'd0, 4'd6, 0, 1, 0));
    // Zero-source write to R3 does not touch the flags
    tbl.push_back(mk(1, 2'b01, 2'd3, 1, 2'd0, 0, 2'd0, 0, 2'b00, 0, 0, 4'd0, 4'd0, 4'd6, 0, 1, 0));
    tbl.push_back(disp(4'd0, 1, 0));

    RST_n = 1'b0;
    bus.Sel1 = '0; bus.WA = '0; bus.WE = 1'b0; bus.RAA = '0; bus.REA = 1'b0;
    bus.RAB = '0; bus.REB = 1'b0; bus.C = '0; bus.Sel2 = 1'b0; bus.Done = 1'b0;
    bus.In1 = '0; bus.In2 = '0;
    @(posedge CLK);
    #1;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Reset on the Op edge discards the partial operands
    run_vec(ld_a(4'd9, 4'd0, 1, 0));
    run_vec(ld_b(4'd5, 4'd0, 1, 0));
    run_vec(mk(0, 2'b00, 2'd3, 1, 2'd1, 1, 2'd2, 1, 2'b00, 1, 1, 4'd0, 4'd0, 4'd0, 0, 0, 0));
    run_vec(mk(1, 2'b00, 2'd0, 0, 2'd1, 1, 2'd2, 1, 2'b00, 1, 1, 4'd0, 4'd0, 4'd0, 1, 0, 0));
    run_vec(disp(4'd0, 0, 0));
    run_vec(ld_a(4'd3, 4'd0, 0, 0));
    run_vec(ld_b(4'd4, 4'd0, 0, 0));
    run_vec(op(2'b00, 4'd0, 0, 0));
    run_vec(disp(4'd7, 0, 0));

    // Same-word write/read of R1 returns the old value; REB=0 masks R2
    run_vec(mk(1, 2'b11, 2'd1, 1, 2'd1, 1, 2'd2, 0, 2'b00, 1, 0, 4'd2, 4'd0, 4'd3, 0, 0, 0));
    run_vec(mk(1, 2'b00, 2'd0, 0, 2'd1, 1, 2'd0, 0, 2'b00, 1, 0, 4'd0, 4'd0, 4'd2, 0, 0, 0));
    // REA=0: add yields port B alone
    run_vec(mk(1, 2'b00, 2'd0, 0, 2'd1, 0, 2'd2, 1, 2'b00, 1, 0, 4'd0, 4'd0, 4'd4, 0, 0, 0));
    // Write-back and result load on the same edge
    run_vec(mk(1, 2'b00, 2'd3, 1, 2'd1, 1, 2'd2, 1, 2'b00, 1, 1, 4'd0, 4'd0, 4'd6, 1, 0, 0));
    run_vec(disp(4'd6, 0, 0));
    run_vec(idle(4'd6, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
